// File: rtl/me_pixel_mem_responder.sv
// Ping-pong pixel frame store answering ME current/reference word reads.
// Optional macro ME_MEM_RESP_PIPE_EN adds an output register stage (read latency 2).
module me_pixel_mem_responder #(
    parameter int unsigned CUR_AW = 10,
    parameter int unsigned REF_AW = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cur_mem_en,
    input  logic [31:0] cur_mem_addr,
    input  logic        ref_mem_en,
    input  logic [31:0] ref_mem_addr,
    output logic [31:0] cur_in_o,
    output logic [63:0] ref_in_o,
    output logic        rd_valid_o,
    output logic        frame_ready_o,
    input  logic        frame_done_i,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic        wr_sel,
    input  logic [31:0] wr_addr,
    input  logic [63:0] wr_data,
    input  logic        wr_last,
    output logic        err_o
);

    localparam int unsigned CUR_DEPTH = 1 << CUR_AW;
    localparam int unsigned REF_DEPTH = 1 << REF_AW;

    logic [31:0] cur_mem [2][CUR_DEPTH];
    logic [63:0] ref_mem [2][REF_DEPTH];

    logic        wr_bank_q, wr_bank_d;
    logic        rd_bank_q, rd_bank_d;
    logic [1:0]  bank_full_q, bank_full_d;
    logic        err_q, err_d;
    logic [31:0] cur_q, cur_d;
    logic [63:0] ref_q, ref_d;
    logic        rd_valid_q, rd_valid_d;

    logic wr_acc, wr_rng_ok, cur_rng_ok, ref_rng_ok, release_ok;
    logic cur_rd_bad, ref_rd_bad;

    always_comb begin
        cur_rng_ok = (cur_mem_addr[31:CUR_AW] == '0);
        ref_rng_ok = (ref_mem_addr[31:REF_AW] == '0);
        wr_rng_ok  = wr_sel ? (wr_addr[31:REF_AW] == '0) : (wr_addr[31:CUR_AW] == '0);

        frame_ready_o = bank_full_q[rd_bank_q];
        wr_ready      = ~bank_full_q[wr_bank_q];
        wr_acc        = wr_valid & wr_ready;
        release_ok    = frame_done_i & frame_ready_o;

        // Fill and release can never target the same bank, so both updates apply in order.
        bank_full_d = bank_full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        if (wr_acc && wr_last) begin
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = ~wr_bank_q;
        end
        if (release_ok) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
        end

        cur_rd_bad = cur_mem_en & ~(frame_ready_o & cur_rng_ok);
        ref_rd_bad = ref_mem_en & ~(frame_ready_o & ref_rng_ok);

        cur_d = cur_q;
        if (cur_mem_en) begin
            cur_d = cur_rd_bad ? '0 : cur_mem[rd_bank_q][cur_mem_addr[CUR_AW-1:0]];
        end
        ref_d = ref_q;
        if (ref_mem_en) begin
            ref_d = ref_rd_bad ? '0 : ref_mem[rd_bank_q][ref_mem_addr[REF_AW-1:0]];
        end
        rd_valid_d = cur_mem_en | ref_mem_en;

        err_d = err_q | (frame_done_i & ~frame_ready_o) | cur_rd_bad | ref_rd_bad
              | (wr_acc & ~wr_rng_ok);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            bank_full_q <= '0;
            err_q       <= 1'b0;
            cur_q       <= '0;
            ref_q       <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            bank_full_q <= bank_full_d;
            err_q       <= err_d;
            cur_q       <= cur_d;
            ref_q       <= ref_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc && wr_rng_ok) begin
            if (wr_sel) begin
                ref_mem[wr_bank_q][wr_addr[REF_AW-1:0]] <= wr_data;
            end else begin
                cur_mem[wr_bank_q][wr_addr[CUR_AW-1:0]] <= wr_data[31:0];
            end
        end
    end

    assign err_o = err_q;

`ifdef ME_MEM_RESP_PIPE_EN
    logic [31:0] cur_p_q;
    logic [63:0] ref_p_q;
    logic        rd_valid_p_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_p_q      <= '0;
            ref_p_q      <= '0;
            rd_valid_p_q <= 1'b0;
        end else begin
            cur_p_q      <= cur_q;
            ref_p_q      <= ref_q;
            rd_valid_p_q <= rd_valid_q;
        end
    end

    assign cur_in_o   = cur_p_q;
    assign ref_in_o   = ref_p_q;
    assign rd_valid_o = rd_valid_p_q;
`else
    assign cur_in_o   = cur_q;
    assign ref_in_o   = ref_q;
    assign rd_valid_o = rd_valid_q;
`endif

endmodule
